bus_arb_mux: RTL
================

BUS_ARB_MUX -- requirements
Module: bus_arb_mux

Interface
REQ-001 Parameter WIDTH, default 16, data bits per channel.
REQ-002 Parameter CHANNELS, default 32, number of source channels, legal range 2..64.
REQ-003 Parameter SEL_W, default $clog2(CHANNELS), channel-index width.
REQ-004 Clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Mode  in  1  0 = direct select by Control, 1 = round-robin arbitration.
REQ-007 Control  in  SEL_W  channel index used in Mode 0 only.
REQ-008 Req  in  CHANNELS  per-channel valid/request.
REQ-009 Data  in  CHANNELS*WIDTH  flattened channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-010 Grant  out  CHANNELS  one-hot-or-zero combinational accept, i.e. ready back to the sources.
REQ-011 Result  out  WIDTH  registered selected data.
REQ-012 Result_Sel  out  SEL_W  registered index of the channel held in Result.
REQ-013 Result_Valid  out  1  Result holds an unconsumed word.
REQ-014 Result_Ready  in  1  downstream accepts Result this cycle.

Function
REQ-015 load_en = !Result_Valid || Result_Ready; while load_en = 0, Grant SHALL be all-zero and Result, Result_Sel and Result_Valid SHALL hold.
REQ-016 A transfer from channel i occurs in a cycle where Grant[i] = 1; in that cycle Req[i] = 1 is guaranteed.
REQ-017 Mode 0: Grant[Control] = load_en && Req[Control]; if Control >= CHANNELS, Grant SHALL be zero.
REQ-018 Mode 1: with pointer P (last granted index), grant the first i with Req[i] = 1, scanning P+1, P+2, ..., CHANNELS-1, 0, ..., P (wrap-around); Grant SHALL be gated by load_en.
REQ-019 P SHALL update to the granted index only on a Mode 1 grant; Mode 0 grants SHALL leave P unchanged.
REQ-020 On a grant from channel i: next cycle Result = Data[i], Result_Sel = i, Result_Valid = 1 (latency 1 cycle).
REQ-021 When load_en = 1 and no grant occurs, next cycle Result_Valid = 0; Result and Result_Sel hold their last values.
REQ-022 Simultaneous drain and grant (Result_Valid = 1, Result_Ready = 1, grant issued) SHALL replace Result with no bubble, sustaining 1 word/cycle.
REQ-023 A Mode change takes effect for the grant decision in the same cycle; a word already in Result SHALL NOT be affected.
REQ-024 Result SHALL never change while Result_Valid = 1 && Result_Ready = 0.
REQ-025 Grant SHALL depend combinationally on Req, Control, Mode, Result_Valid, Result_Ready and P only (no path from Data).

Reset
REQ-026 Reset SHALL set Result = 0, Result_Sel = 0, Result_Valid = 0 and P = CHANNELS-1, so the first Mode 1 grant favours channel 0.
REQ-027 While Reset = 1, Grant SHALL be all-zero; a word held in Result at reset assertion is discarded.
REQ-028 Req and Data are don't-care during Reset; the first grant is possible in the first cycle with Reset = 0.

Structure
REQ-029 Mode encodings (MODE_DIRECT = 0, MODE_RR = 1) SHALL live in shared package bus_pkg.
REQ-030 The round-robin priority search and pointer SHALL be the sub-module rr_arbiter (parameter CHANNELS; inputs Req and enable; outputs Grant and index).
REQ-031 Data selection SHALL be an indexed part-select, not a hand-unrolled conditional tree.

Verification
REQ-032 Mode 0, Control = 5, Req = all-ones, Data[5] = 16'hBEEF, Result_Ready = 1 -> Grant = 1<<5; next cycle Result = BEEF, Result_Sel = 5, Result_Valid = 1.
REQ-033 Mode 1 after reset, Req = all-ones held for 33 cycles, Result_Ready = 1 -> grants 0, 1, ..., 31, 0 in order (wrap-around).
REQ-034 Mode 1, Req = {3, 17} only, Result_Ready = 1 -> grants alternate 3, 17, 3, 17.
REQ-035 Result_Valid = 1, Result_Ready = 0 for 4 cycles with Req active -> Grant = 0 and Result stable for all 4 cycles; raise Result_Ready -> the new word is loaded the next cycle with no bubble.
REQ-036 Reset asserted while Result_Valid = 1 -> next cycle Result_Valid = 0, Result = 0; first Mode 1 grant after release goes to channel 0.
REQ-037 Mode 0, Control = 31 with CHANNELS = 24 -> Grant = 0 and Result_Valid falls to 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbitration mux.
// Holds the mode encodings used by the top and by the testbench.
package bus_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search with a last-granted pointer.
// The scan starts just after the pointer and wraps, so the pointer's own channel comes last.
module rr_arbiter #(
  parameter int CHANNELS = 32,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] Req,
  input  logic                enable,
  output logic [CHANNELS-1:0] Grant,
  output logic [SEL_W-1:0]    index
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               idx;

  always_comb begin
    found = 1'b0;
    index = ptr_q;
    idx   = 0;
    Grant = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && Req[SEL_W'(idx)]) begin
        found = 1'b1;
        index = SEL_W'(idx);
      end
    end
    Grant[index] = found && enable;
  end

  // The pointer only advances on a grant that actually happens.
  assign ptr_d = (found && enable) ? index : ptr_q;

  always_ff @(posedge Clk) begin
    if (Reset) ptr_q <= SEL_W'(CHANNELS - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bus_arb_mux.sv
// Multi-channel arbiter/mux: direct or round-robin selection into a one-word output register.
// Grant is the combinational ready back to the sources; Result is a valid/ready skid-free stage.
module bus_arb_mux
  import bus_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 32,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Mode,
  input  logic [SEL_W-1:0]          Control,
  input  logic [CHANNELS-1:0]       Req,
  input  logic [CHANNELS*WIDTH-1:0] Data,
  output logic [CHANNELS-1:0]       Grant,
  output logic [WIDTH-1:0]          Result,
  output logic [SEL_W-1:0]          Result_Sel,
  output logic                      Result_Valid,
  input  logic                      Result_Ready
);

  logic [WIDTH-1:0]    result_q, result_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                valid_q, valid_d;
  logic                load_en, rr_en, ctrl_in_range, any_grant;
  logic [CHANNELS-1:0] rr_grant;
  logic [SEL_W-1:0]    rr_index, grant_idx;
  int                  sel_base;

  assign load_en       = !valid_q || Result_Ready;
  assign ctrl_in_range = int'(Control) < CHANNELS;
  assign rr_en         = !Reset && load_en && (mode_e'(Mode) == MODE_RR);

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr (
    .Clk    (Clk),
    .Reset  (Reset),
    .Req    (Req),
    .enable (rr_en),
    .Grant  (rr_grant),
    .index  (rr_index)
  );

  always_comb begin
    Grant     = '0;
    grant_idx = Control;
    if (!Reset) begin
      if (mode_e'(Mode) == MODE_RR) begin
        Grant     = rr_grant;
        grant_idx = rr_index;
      end else if (load_en && ctrl_in_range && Req[Control]) begin
        Grant[Control] = 1'b1;
      end
    end
  end

  assign any_grant = |Grant;
  assign sel_base  = int'(grant_idx) * WIDTH;

  always_comb begin
    result_d = result_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    if (load_en) begin
      valid_d = any_grant;
      if (any_grant) begin
        result_d = Data[sel_base +: WIDTH];
        sel_d    = grant_idx;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      result_q <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
    end
  end

  assign Result       = result_q;
  assign Result_Sel   = sel_q;
  assign Result_Valid = valid_q;

endmodule
